// File: rtl/prio_encoder_drain_if.sv
// Handshake bundle for prio_encoder_drain: request vector in, serialised index stream out.
// out_remain is present only when PRIO_ENC_COUNT_EN is defined.
interface prio_encoder_drain_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;
`ifdef PRIO_ENC_COUNT_EN
    logic [W:0]   out_remain;
`endif

    modport master (
`ifdef PRIO_ENC_COUNT_EN
        input  out_remain,
`endif
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none
    );

    modport slave (
`ifdef PRIO_ENC_COUNT_EN
        output out_remain,
`endif
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none
    );
endinterface

// File: rtl/prio_encoder_drain.sv
// Registered priority encoder that drains a captured multi-hot vector as a stream of indices.
// Optional feature macro: PRIO_ENC_COUNT_EN (adds out_remain = bits left including current beat).
module prio_encoder_drain #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    prio_encoder_drain_if.slave bus
);
    localparam int W = $clog2(N);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]   r_state;
    logic [N-1:0] r_vec;

    logic         w_busy;
    logic [W-1:0] w_idx;
    logic [N-1:0] w_onehot;
    logic         w_last;
    logic         w_none;
    logic         w_hs;
    logic         w_accept;

    assign w_busy = (r_state == BUSY);

    // The last matching bit in scan order wins, so scan away from the priority end.
    always_comb begin
        w_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (r_vec[i]) w_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r_vec[i]) w_idx = W'(i);
            end
        end
    end

    assign w_onehot = N'(1) << w_idx;
    assign w_last   = ((r_vec & (r_vec - N'(1))) == '0);
    assign w_none   = (r_vec == '0);
    assign w_hs     = w_busy & bus.out_ready;
    assign w_accept = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = rst_n & (~w_busy | (w_last & bus.out_ready));
    assign bus.out_valid = w_busy;
    assign bus.out_idx   = w_busy ? w_idx : '0;
    assign bus.out_last  = w_busy & w_last;
    assign bus.out_none  = w_busy & w_none;

    // An accept while busy can only coincide with the last-beat handshake, so it simply reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
        end else if (w_accept) begin
            r_state <= BUSY;
            r_vec   <= bus.in_vec;
        end else if (w_hs) begin
            if (w_last) begin
                r_state <= IDLE;
                r_vec   <= '0;
            end else begin
                r_vec   <= r_vec & ~w_onehot;
            end
        end
    end

`ifdef PRIO_ENC_COUNT_EN
    localparam int WC = W + 1;

    logic [W:0] w_count;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N; i++) begin
            w_count = w_count + WC'(r_vec[i]);
        end
    end

    assign bus.out_remain = w_busy ? w_count : '0;
`endif

endmodule
